// File: rtl/result_fifo.sv
// First-word-fall-through result buffer behind the exponential wrapper, with
// a sticky overflow flag and a saturating count of completed wrapper jobs.
module result_fifo #(
   parameter int DATA_W = 21,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_reg,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              w_done,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  level,
   output logic              ovf,
   input  logic              clr_ovf,
   output logic [7:0]        job_cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wrptr;
   logic [PTR_W-1:0]  rdptr;
   logic              push;
   logic              pop;
   logic              drop;

   assign empty    = (level == '0);
   assign full     = (level == CNT_W'(DEPTH));
   assign rd_valid = !empty;
   assign rd_data  = empty ? '0 : mem[rdptr];

   // A pop frees the slot the same cycle, so a push at full is still accepted.
   assign pop  = rd_valid & rd_ready;
   assign push = wr_reg & (!full | pop);
   assign drop = wr_reg & full & !pop;

   // NOTE: the storage array carries no reset; stale words are unreachable
   // because level gates rd_data, and leaving it out keeps plain flop arrays.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wrptr] <= wr_data;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrptr <= '0;
         rdptr <= '0;
         level <= '0;
      end else begin
         if (push) wrptr <= wrptr + 1'b1;
         if (pop)  rdptr <= rdptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // A drop in the same cycle as clr_ovf leaves the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         job_cnt <= '0;
      end else if (w_done && job_cnt != 8'hFF) begin
         job_cnt <= job_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_result_fifo.sv
// Self-checking bench for result_fifo: directed test-plan steps plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_result_fifo;

   localparam int DATA_W = 21;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wr_reg = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              w_done = 1'b0;
   logic              rd_ready = 1'b0;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  level;
   logic              ovf;
   logic              clr_ovf = 1'b0;
   logic [7:0]        job_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference model: occupancy is the queue length, head is q[0].
   logic [DATA_W-1:0] q[$];
   logic              ovf_m = 1'b0;
   int                job_m = 0;
   logic [DATA_W-1:0] sent[$];
   logic [DATA_W-1:0] got[$];

   result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_reg(wr_reg), .wr_data(wr_data),
      .w_done(w_done), .rd_ready(rd_ready), .rd_valid(rd_valid),
      .rd_data(rd_data), .full(full), .empty(empty), .level(level),
      .ovf(ovf), .clr_ovf(clr_ovf), .job_cnt(job_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      check({tag, ".level"},    32'(level),    32'(n));
      check({tag, ".empty"},    32'(empty),    32'(n == 0));
      check({tag, ".full"},     32'(full),     32'(n == DEPTH));
      check({tag, ".rd_valid"}, 32'(rd_valid), 32'(n != 0));
      check({tag, ".rd_data"},  32'(rd_data),  (n != 0) ? 32'(q[0]) : 32'd0);
      check({tag, ".ovf"},      32'(ovf),      32'(ovf_m));
      check({tag, ".job_cnt"},  32'(job_cnt),  32'(job_m));
   endtask

   // Drive one cycle of inputs, advance the model at the edge, then compare.
   task automatic step(input string tag, input logic r, input logic wr,
                       input logic [DATA_W-1:0] d, input logic wd,
                       input logic rr, input logic co);
      logic was_full;
      logic p;
      rst = r; wr_reg = wr; wr_data = d; w_done = wd; rd_ready = rr; clr_ovf = co;
      @(posedge clk);
      if (r) begin
         q.delete();
         ovf_m = 1'b0;
         job_m = 0;
      end else begin
         was_full = (q.size() == DEPTH);
         p = rr && (q.size() != 0);
         if (p) got.push_back(q.pop_front());
         if (wr && (!was_full || p)) q.push_back(d);
         if (wr && was_full && !p) ovf_m = 1'b1;
         else if (co) ovf_m = 1'b0;
         if (wd && job_m != 255) job_m++;
      end
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      @(posedge clk);
      #1;

      // Reset dominates wr_reg and w_done.
      step("rst0", 1'b1, 1'b1, 21'h1, 1'b1, 1'b0, 1'b0);
      step("rst1", 1'b1, 1'b1, 21'h2, 1'b1, 1'b0, 1'b0);
      check("rst.level_zero", 32'(level), 32'd0);
      check("rst.rd_data_zero", 32'(rd_data), 32'd0);

      // Single word, held under back-pressure, then popped.
      step("single.push", 1'b0, 1'b1, 21'h1ABCDE, 1'b0, 1'b0, 1'b0);
      check("single.word", 32'(rd_data), 32'h1ABCDE);
      idle("single.hold");
      step("single.pop", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("single.empty", 32'(empty), 32'd1);

      // Fill, overflow, ordered drain, clear.
      for (int i = 1; i <= DEPTH; i++) step("fill", 1'b0, 1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
      check("fill.full", 32'(full), 32'd1);
      step("drop9", 1'b0, 1'b1, 21'd9, 1'b0, 1'b0, 1'b0);
      check("drop9.ovf", 32'(ovf), 32'd1);
      got.delete();
      for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) check("drain.order", 32'(got[i]), 32'(i + 1));
      step("clr", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("clr.ovf", 32'(ovf), 32'd0);

      // Drop coincident with clr_ovf: set wins.
      for (int i = 1; i <= DEPTH; i++) step("refill", 1'b0, 1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
      step("drop_clr", 1'b0, 1'b1, 21'd77, 1'b0, 1'b0, 1'b1);
      check("drop_clr.ovf", 32'(ovf), 32'd1);
      step("clr2", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Push and pop together at full, then read 2..9.
      step("full_pp", 1'b0, 1'b1, 21'd9, 1'b0, 1'b1, 1'b0);
      check("full_pp.level", 32'(level), 32'd8);
      check("full_pp.ovf", 32'(ovf), 32'd0);
      got.delete();
      for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) check("drain2.order", 32'(got[i]), 32'(i + 2));

      // Push with rd_ready while empty: push only.
      step("empty_pp", 1'b0, 1'b1, 21'h155, 1'b0, 1'b1, 1'b0);
      check("empty_pp.level", 32'(level), 32'd1);
      step("empty_pp.pop", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Stream 20 random words with rd_ready toggling; throttle on full.
      sent.delete();
      got.delete();
      begin
         int n_sent;
         int cyc;
         logic [DATA_W-1:0] w;
         n_sent = 0;
         cyc = 0;
         while ((n_sent < 20 || q.size() != 0) && cyc < 200) begin
            w = DATA_W'($urandom);
            if (n_sent < 20 && q.size() < DEPTH) begin
               sent.push_back(w);
               n_sent++;
               step("wrap", 1'b0, 1'b1, w, 1'b0, cyc[0] == 1'b0, 1'b0);
            end else begin
               step("wrap", 1'b0, 1'b0, w, 1'b0, cyc[0] == 1'b0, 1'b0);
            end
            check("wrap.level_bound", 32'(level <= CNT_W'(DEPTH)), 32'd1);
            cyc++;
         end
         check("wrap.count", 32'(got.size()), 32'd20);
         for (int i = 0; i < 20 && i < got.size(); i++)
            check("wrap.order", 32'(got[i]), 32'(sent[i]));
      end

      // Random traffic on every input except reset.
      for (int i = 0; i < 300; i++)
         step("rand", 1'b0, ($urandom % 3) != 0, DATA_W'($urandom), ($urandom % 4) == 0,
              ($urandom % 2) == 0, ($urandom % 8) == 0);

      // Job counter saturation.
      step("jrst", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 260; i++) step("job", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("job.sat", 32'(job_cnt), 32'd255);

      // Reset mid-operation with five words buffered.
      for (int i = 0; i < 5; i++) step("pre", 1'b0, 1'b1, DATA_W'(32'h100 + i), 1'b0, 1'b0, 1'b0);
      check("pre.level", 32'(level), 32'd5);
      step("mid_rst", 1'b1, 1'b1, 21'h3, 1'b1, 1'b1, 1'b0);
      check("mid_rst.level", 32'(level), 32'd0);
      check("mid_rst.job", 32'(job_cnt), 32'd0);
      step("post", 1'b0, 1'b1, 21'h00042, 1'b0, 1'b0, 1'b0);
      check("post.first", 32'(rd_data), 32'h42);
      step("post.pop", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/result_fifo.md
# result_fifo

Output buffer directly downstream of the exponential wrapper. Captures each `wr_data` word on the wrapper's `wr_reg` strobe into a first-word-fall-through FIFO, presents it on a valid/ready read port, and counts completed wrapper jobs (`w_done` pulses). Buffers results when the consumer stalls and exposes `full` so the issuing controller can hold off the next `w_start`.

## Interface

Parameters:
- `DATA_W`, 21: word width; matches the wrapper's `wr_data`.
- `DEPTH`, 8: number of entries; must be a power of two and at least 2.
- `CNT_W`, $clog2(DEPTH)+1: width of `level`. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `wr_reg`  in  1  push strobe from the wrapper; one word per high cycle.
- `wr_data`  in  DATA_W  word to push.
- `w_done`  in  1  job-complete pulse from the wrapper.
- `rd_ready`  in  1  consumer accepts the head word this cycle.
- `rd_valid`  out  1  head word is valid. Equal to `!empty`.
- `rd_data`  out  DATA_W  head word. Forced to 0 when empty.
- `full`  out  1  `level == DEPTH`.
- `empty`  out  1  `level == 0`.
- `level`  out  CNT_W  current occupancy, 0 to DEPTH.
- `ovf`  out  1  sticky overflow flag.
- `clr_ovf`  in  1  clears `ovf`.
- `job_cnt`  out  8  count of `w_done` pulses; saturates at 255.

## Operation

- **Storage:** DEPTH×DATA_W register array, a write pointer and a read pointer, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. Occupancy is tracked by the registered `level` counter, not derived from pointer comparison. The array itself is not reset.
- **Pop:** `pop = rd_valid & rd_ready`.
- **Push:**
  - `push = wr_reg & (!full | pop)`.
  - A push and a pop in the same cycle at full is legal. Both take effect and `level` is unchanged.
- **Drop:** `wr_reg & full & !pop`. The word is discarded, `wrptr` does not move, and `ovf` is set.
- **Level update:** +1 on push only; −1 on pop only; unchanged on both or neither.
- **Read path:** `rd_data = empty ? 0 : mem[rdptr]`. This is a combinational read of registered state; there is no combinational path from `wr_*` to `rd_*`.
- **Overflow flag:** `ovf` is set by a drop and cleared by `clr_ovf`. If a drop and `clr_ovf` occur in the same cycle, set wins.
- **Job counter:** `job_cnt` increments on each `w_done` high cycle and holds at 255. It is independent of FIFO state; a `w_done` coincident with `wr_reg` does both actions.
- **Control:** no FSM beyond the pointer/level datapath. The mode is implied by `level`: EMPTY (0), PARTIAL, or FULL (DEPTH).

## Timing

- **Reset** (`rst` high at an edge) sets:
  - `wrptr = rdptr = 0`, `level = 0`, `ovf = 0`, `job_cnt = 0`.
  - Outputs after the edge: `rd_valid = 0`, `rd_data = 0`, `empty = 1`, `full = 0`.
  - `rst` overrides every other input in the same cycle.
  - Reset mid-operation discards all buffered words.
- **Push-to-read latency: 1 cycle.** A word pushed at edge k is visible on `rd_data`, with `rd_valid = 1`, during the cycle after edge k.
- **Empty boundary:** `wr_reg` and `rd_ready` high together while empty gives push only and no pop. `level` becomes 1.
- **Pop timing:** a pop at edge k advances `rdptr`, and the next word (or 0 if now empty) appears after edge k.
- **Flag timing:** `full`, `empty`, `level`, `ovf` and `job_cnt` are all registered or derived from registered state, and update on the edge following the causing event.
- **Back-pressure:** the consumer may hold `rd_ready` low indefinitely. `rd_data` and `rd_valid` stay stable until popped.
- **Upstream throughput:** one push per cycle is accepted. `full` is the sole throttle signal.

## Test plan

- **Reset values:** assert `rst` for 2 cycles with `wr_reg` = 1 and `w_done` = 1 → `level` = 0, `empty` = 1, `rd_data` = 0, `ovf` = 0, `job_cnt` = 0.
- **Single word:** push 21'h1ABCDE with `rd_ready` low → next cycle `rd_valid` = 1, `rd_data` = 21'h1ABCDE, `level` = 1. Raise `rd_ready` for one cycle → `empty` = 1, `rd_data` = 0.
- **Fill, overflow and order:**
  - Push 1..8 with no reads → `full` = 1, `level` = 8.
  - Push 9 → `ovf` = 1, `level` stays 8.
  - Drain → words read out as 1..8 in order, 9 absent.
  - `clr_ovf` → `ovf` = 0.
  - `clr_ovf` coincident with another drop → `ovf` stays 1.
- **Simultaneous push/pop:**
  - At full holding 1..8, push 9 with `rd_ready` = 1 → `level` stays 8, `ovf` = 0. Subsequent reads give 2..9.
  - At empty, push + `rd_ready` → `level` = 1.
- **Wrap-around:** stream 20 words with `rd_ready` toggling 1/0 each cycle → the output sequence exactly matches the input sequence across several pointer wraps, and `level` never exceeds 8.
- **Job counter and mid-operation reset:**
  - 260 `w_done` pulses → `job_cnt` = 255.
  - With `level` = 5, assert `rst` for one cycle → `level` = 0, `job_cnt` = 0. A following push of 21'h00042 reads back as the first word.
